// File: rtl/cnna_pkg.sv
// Shared constants and helpers for the multi-channel accumulate RAM.
package cnna_pkg;

    // Beat acceptance to RAM write commit, in cycles
    localparam int C_PIPE_DEPTH = 3;

    // Low bit of channel k when channels of width w are packed side by side
    function automatic int ch_lo(input int k, input int w);
        return k * w;
    endfunction

    // Most positive two's-complement value of a dsize-bit word
    function automatic logic signed [63:0] sat_max(input int dsize);
        return (64'sd1 <<< (dsize - 1)) - 64'sd1;
    endfunction

    // Most negative two's-complement value of a dsize-bit word
    function automatic logic signed [63:0] sat_min(input int dsize);
        return -(64'sd1 <<< (dsize - 1));
    endfunction

endpackage

// File: rtl/acc_bank_ram.sv
// Dual-bank accumulator storage: one write port, two registered read ports
// (one feeding the accumulate pipeline, one serving host reads). The bank is
// the address MSB. Reads are read-first against a same-cycle write.
module acc_bank_ram #(
    parameter     C_MEM_STYLE = "block",
    parameter int C_WIDTH     = 96,
    parameter int C_AWIDTH    = 11
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [C_AWIDTH-1:0] i_waddr,
    input  logic [C_WIDTH-1:0]  i_wdata,
    input  logic                i_are,
    input  logic [C_AWIDTH-1:0] i_araddr,
    output logic [C_WIDTH-1:0]  o_ardata,
    input  logic                i_hre,
    input  logic [C_AWIDTH-1:0] i_hraddr,
    output logic [C_WIDTH-1:0]  o_hrdata
);

    localparam int L_DEPTH = 1 << C_AWIDTH;

    logic [C_WIDTH-1:0] r_ardata;
    logic [C_WIDTH-1:0] r_hrdata;

    if (C_MEM_STYLE == "block") begin : g_block
        (* ram_style = "block" *) logic [C_WIDTH-1:0] r_mem [L_DEPTH];

        // Write port
        always_ff @(posedge i_clk)
            if (i_we) r_mem[i_waddr] <= i_wdata;

        // Accumulate-side registered read
        always_ff @(posedge i_clk)
            if (i_are) r_ardata <= r_mem[i_araddr];

        // Host-side registered read
        always_ff @(posedge i_clk)
            if (i_hre) r_hrdata <= r_mem[i_hraddr];
    end else begin : g_other
        (* ram_style = C_MEM_STYLE *) logic [C_WIDTH-1:0] r_mem [L_DEPTH];

        // Write port
        always_ff @(posedge i_clk)
            if (i_we) r_mem[i_waddr] <= i_wdata;

        // Accumulate-side registered read
        always_ff @(posedge i_clk)
            if (i_are) r_ardata <= r_mem[i_araddr];

        // Host-side registered read
        always_ff @(posedge i_clk)
            if (i_hre) r_hrdata <= r_mem[i_hraddr];
    end

    assign o_ardata = r_ardata;
    assign o_hrdata = r_hrdata;

endmodule

// File: rtl/multi_ch_acc_ram.sv
// Multi-channel read-modify-write accumulator over a ping-pong RAM.
// Stages: S0 capture, S1 RAM read, S2 add (sum registered, drives the RAM
// write), S3 holds the just-written sum so a gap-1 follower can forward it.
module multi_ch_acc_ram
    import cnna_pkg::*;
#(
    parameter     C_MEM_STYLE = "block",
    parameter int C_CH        = 4,
    parameter int C_ISIZE     = 12,
    parameter int C_DSIZE     = 24,
    parameter int C_ASIZE     = 10,
    parameter int C_SAT_EN    = 1
) (
    input  logic                      I_clk,
    input  logic                      I_rst,
    input  logic                      I_bank_sel,
    input  logic                      I_first_flag,
    input  logic                      I_din_valid,
    input  logic [C_ASIZE-1:0]        I_waddr,
    input  logic [C_CH*C_ISIZE-1:0]   I_din,
    input  logic                      I_rd_en,
    input  logic [C_ASIZE-1:0]        I_raddr,
    input  logic                      I_clr_sat,
    output logic [C_CH*C_DSIZE-1:0]   O_rdata,
    output logic                      O_rdata_valid,
    output logic [C_CH-1:0]           O_sat_flag,
    output logic                      O_pipe_empty
);

    localparam int L_IW = C_CH * C_ISIZE;
    localparam int L_DW = C_CH * C_DSIZE;
    localparam logic [C_DSIZE-1:0] L_SMAX = C_DSIZE'(sat_max(C_DSIZE));
    localparam logic [C_DSIZE-1:0] L_SMIN = C_DSIZE'(sat_min(C_DSIZE));

    logic [C_PIPE_DEPTH:0] r_vld;
    logic [L_IW-1:0]       r_s0_din, r_s1_din;
    logic [C_ASIZE-1:0]    r_s0_addr, r_s1_addr, r_s2_addr, r_s3_addr;
    logic                  r_s0_bank, r_s1_bank, r_s2_bank, r_s3_bank;
    logic                  r_s0_first, r_s1_first;
    logic [L_DW-1:0]       r_s2_sum, r_s3_sum;
    logic                  r_rd_pend;
    logic                  r_rdata_valid;
    logic [L_DW-1:0]       r_rdata;
    logic [C_CH-1:0]       r_sat;

    logic [L_DW-1:0]       w_ram_old, w_host_rd, w_old, w_sum;
    logic [C_CH-1:0]       w_ovf;
    logic                  w_fwd_s2, w_fwd_s3;

    // Stage valids; bit k is stage Sk. Reset drops every beat in flight.
    always_ff @(posedge I_clk or posedge I_rst)
        if (I_rst) r_vld <= '0;
        else       r_vld <= {r_vld[C_PIPE_DEPTH-1:0], I_din_valid};

    // Stage payloads; the bank is latched with the beat so later toggles cannot redirect it
    always_ff @(posedge I_clk) begin
        r_s0_din   <= I_din;
        r_s0_addr  <= I_waddr;
        r_s0_bank  <= I_bank_sel;
        r_s0_first <= I_first_flag;
        r_s1_din   <= r_s0_din;
        r_s1_addr  <= r_s0_addr;
        r_s1_bank  <= r_s0_bank;
        r_s1_first <= r_s0_first;
        r_s2_sum   <= w_sum;
        r_s2_addr  <= r_s1_addr;
        r_s2_bank  <= r_s1_bank;
        r_s3_sum   <= r_s2_sum;
        r_s3_addr  <= r_s2_addr;
        r_s3_bank  <= r_s2_bank;
    end

    acc_bank_ram #(
        .C_MEM_STYLE (C_MEM_STYLE),
        .C_WIDTH     (L_DW),
        .C_AWIDTH    (C_ASIZE + 1)
    ) u_ram (
        .i_clk    (I_clk),
        .i_we     (r_vld[2]),
        .i_waddr  ({r_s2_bank, r_s2_addr}),
        .i_wdata  (r_s2_sum),
        .i_are    (r_vld[0]),
        .i_araddr ({r_s0_bank, r_s0_addr}),
        .o_ardata (w_ram_old),
        .i_hre    (I_rd_en),
        .i_hraddr ({~I_bank_sel, I_raddr}),
        .o_hrdata (w_host_rd)
    );

    // S2 is one beat older than S1 (not yet written); S3 was written on the
    // same edge that S1 read the RAM, so the RAM word is stale in both cases.
    assign w_fwd_s2 = r_vld[2] && ({r_s2_bank, r_s2_addr} == {r_s1_bank, r_s1_addr});
    assign w_fwd_s3 = r_vld[3] && ({r_s3_bank, r_s3_addr} == {r_s1_bank, r_s1_addr});
    assign w_old    = r_s1_first ? '0 :
                      w_fwd_s2   ? r_s2_sum :
                      w_fwd_s3   ? r_s3_sum : w_ram_old;

    for (genvar k = 0; k < C_CH; k++) begin : g_ch
        logic [C_DSIZE-1:0] w_a;
        logic [C_ISIZE-1:0] w_b;
        logic [C_DSIZE:0]   w_full;

        assign w_a      = w_old[ch_lo(k, C_DSIZE) +: C_DSIZE];
        assign w_b      = r_s1_din[ch_lo(k, C_ISIZE) +: C_ISIZE];
        assign w_full   = {w_a[C_DSIZE-1], w_a}
                        + {{(C_DSIZE + 1 - C_ISIZE){w_b[C_ISIZE-1]}}, w_b};
        assign w_ovf[k] = w_full[C_DSIZE] ^ w_full[C_DSIZE-1];

        if (C_SAT_EN != 0) begin : g_sat
            assign w_sum[ch_lo(k, C_DSIZE) +: C_DSIZE] =
                w_ovf[k] ? (w_full[C_DSIZE] ? L_SMIN : L_SMAX) : w_full[C_DSIZE-1:0];
        end else begin : g_wrap
            assign w_sum[ch_lo(k, C_DSIZE) +: C_DSIZE] = w_full[C_DSIZE-1:0];
        end
    end

    // Host read: RAM register then output register; data holds between reads
    always_ff @(posedge I_clk or posedge I_rst)
        if (I_rst) begin
            r_rd_pend     <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
        end else begin
            r_rd_pend     <= I_rd_en;
            r_rdata_valid <= r_rd_pend;
            if (r_rd_pend) r_rdata <= w_host_rd;
        end

    // Sticky overflow flags, set as the sum leaves S1; clear wins over set
    always_ff @(posedge I_clk or posedge I_rst)
        if (I_rst)          r_sat <= '0;
        else if (I_clr_sat) r_sat <= '0;
        else if (r_vld[1])  r_sat <= r_sat | w_ovf;

    assign O_rdata       = r_rdata;
    assign O_rdata_valid = r_rdata_valid;
    assign O_sat_flag    = r_sat;
    assign O_pipe_empty  = ~|r_vld;

endmodule

// File: tb/tb_multi_ch_acc_ram.sv
// Bench for multi_ch_acc_ram: a saturating and a wrapping instance share
// stimulus; a per-bank/per-address/per-channel array model gives expectations.
module tb_multi_ch_acc_ram;

    localparam int CH = 4;
    localparam int IS = 12;
    localparam int DS = 16;
    localparam int AS = 4;
    localparam longint SMAX = 32767;
    localparam longint SMIN = -32768;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bank_sel = 1'b0;
    logic              first = 1'b0;
    logic              din_valid = 1'b0;
    logic [AS-1:0]     waddr = '0;
    logic [CH*IS-1:0]  din = '0;
    logic              rd_en = 1'b0;
    logic [AS-1:0]     raddr = '0;
    logic              clr_sat = 1'b0;

    logic [CH*DS-1:0]  rdata_s, rdata_w;
    logic              rvld_s, rvld_w, empty_s, empty_w;
    logic [CH-1:0]     sat_s, sat_w;

    int                n_tests = 0;
    int                n_fail = 0;
    longint            m_sat  [2][1<<AS][CH];
    longint            m_wrap [2][1<<AS][CH];
    logic [CH-1:0]     exp_sat_s = '0;
    logic [CH-1:0]     exp_sat_w = '0;

    always #5 clk = ~clk;

    multi_ch_acc_ram #(.C_CH(CH), .C_ISIZE(IS), .C_DSIZE(DS), .C_ASIZE(AS), .C_SAT_EN(1)) u_sat (
        .I_clk(clk), .I_rst(rst), .I_bank_sel(bank_sel), .I_first_flag(first),
        .I_din_valid(din_valid), .I_waddr(waddr), .I_din(din), .I_rd_en(rd_en),
        .I_raddr(raddr), .I_clr_sat(clr_sat), .O_rdata(rdata_s), .O_rdata_valid(rvld_s),
        .O_sat_flag(sat_s), .O_pipe_empty(empty_s)
    );

    multi_ch_acc_ram #(.C_CH(CH), .C_ISIZE(IS), .C_DSIZE(DS), .C_ASIZE(AS), .C_SAT_EN(0)) u_wrap (
        .I_clk(clk), .I_rst(rst), .I_bank_sel(bank_sel), .I_first_flag(first),
        .I_din_valid(din_valid), .I_waddr(waddr), .I_din(din), .I_rd_en(rd_en),
        .I_raddr(raddr), .I_clr_sat(clr_sat), .O_rdata(rdata_w), .O_rdata_valid(rvld_w),
        .O_sat_flag(sat_w), .O_pipe_empty(empty_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: each beat is an ordinary sequential read-add-write
    task automatic model_beat(input bit b, input int a, input bit f, input int d[CH]);
        for (int k = 0; k < CH; k++) begin
            longint s_s = (f ? 64'sd0 : m_sat[b][a][k]) + longint'(d[k]);
            longint s_w = (f ? 64'sd0 : m_wrap[b][a][k]) + longint'(d[k]);
            if (s_s > SMAX)      begin s_s = SMAX; exp_sat_s[k] = 1'b1; end
            else if (s_s < SMIN) begin s_s = SMIN; exp_sat_s[k] = 1'b1; end
            if (s_w > SMAX)      begin s_w = s_w - 65536; exp_sat_w[k] = 1'b1; end
            else if (s_w < SMIN) begin s_w = s_w + 65536; exp_sat_w[k] = 1'b1; end
            m_sat[b][a][k]  = s_s;
            m_wrap[b][a][k] = s_w;
        end
    endtask

    task automatic beat(input bit b, input int a, input bit f, input int d[CH], input bit commit);
        bank_sel  = b;
        waddr     = AS'(a);
        first     = f;
        din_valid = 1'b1;
        for (int k = 0; k < CH; k++) din[k*IS +: IS] = IS'(d[k]);
        if (commit) model_beat(b, a, f, d);
        tick();
        din_valid = 1'b0;
        first     = 1'b0;
    endtask

    task automatic rand_din(output int d[CH]);
        for (int k = 0; k < CH; k++) d[k] = int'($urandom_range(4094, 0)) - 2047;
    endtask

    task automatic check_flags(input string tag);
        check($sformatf("%s_flag_sat", tag),  64'(sat_s), 64'(exp_sat_s));
        check($sformatf("%s_flag_wrap", tag), 64'(sat_w), 64'(exp_sat_w));
    endtask

    // Reads bank b (by driving the opposite write bank) and checks 2-cycle latency and data
    task automatic rd_check(input string tag, input bit b, input int a);
        logic [63:0] exp_s;
        logic [63:0] exp_w;
        for (int k = 0; k < CH; k++) begin
            exp_s[k*DS +: DS] = DS'(m_sat[b][a][k]);
            exp_w[k*DS +: DS] = DS'(m_wrap[b][a][k]);
        end
        bank_sel = ~b;
        raddr    = AS'(a);
        rd_en    = 1'b1;
        tick();
        rd_en = 1'b0;
        check($sformatf("%s_vld_early", tag), 64'(rvld_s), 64'd0);
        tick();
        check($sformatf("%s_vld_sat", tag),  64'(rvld_s), 64'd1);
        check($sformatf("%s_vld_wrap", tag), 64'(rvld_w), 64'd1);
        check($sformatf("%s_data_sat", tag),  64'(rdata_s), exp_s);
        check($sformatf("%s_data_wrap", tag), 64'(rdata_w), exp_w);
        tick();
        check($sformatf("%s_vld_late", tag), 64'(rvld_s), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d[CH];
        int a;
        bit b;

        // Reset state
        #1;
        check("rst_empty_sat",  64'(empty_s), 64'd1);
        check("rst_empty_wrap", 64'(empty_w), 64'd1);
        check("rst_flag_sat",   64'(sat_s),   64'd0);
        check("rst_rvld",       64'(rvld_s),  64'd0);
        check("rst_rdata",      64'(rdata_s), 64'd0);
        idle(3);
        rst = 1'b0;
        tick();

        // First-flag accumulation: 3 + 3 + 3 + 3 back to back
        d = '{3, 3, 3, 3};
        beat(0, 5, 1, d, 1);
        check("busy_empty", 64'(empty_s), 64'd0);
        beat(0, 5, 0, d, 1);
        beat(0, 5, 0, d, 1);
        beat(0, 5, 0, d, 1);
        idle(4);
        check("drained_empty", 64'(empty_s), 64'd1);
        rd_check("first_acc", 0, 5);

        // Saturation / wrap: +2047 twenty times
        d = '{2047, 2047, 2047, 2047};
        beat(1, 2, 1, d, 1);
        for (int i = 0; i < 19; i++) beat(1, 2, 0, d, 1);
        idle(4);
        check_flags("sat20");
        rd_check("sat20", 1, 2);
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        exp_sat_s = '0;
        exp_sat_w = '0;
        check_flags("clr");

        // Clear coincides with the overflow set: clear must win
        beat(1, 2, 0, d, 1);
        tick();
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        exp_sat_s = '0;
        exp_sat_w = '0;
        check_flags("clr_prio");
        idle(3);
        rd_check("sat_hold", 1, 2);

        // Same-address hazards at gaps 0..3
        for (int g = 0; g < 4; g++) begin
            a = int'($urandom_range(15, 10));
            b = 1'($urandom_range(1, 0));
            for (int i = 0; i < 6; i++) begin
                rand_din(d);
                beat(b, a, (i == 0), d, 1);
                idle(g);
            end
            idle(4);
            rd_check($sformatf("gap%0d", g), b, a);
        end
        check_flags("gaps");

        // Bank alternating every beat on one address
        rand_din(d); beat(0, 7, 1, d, 1);
        rand_din(d); beat(1, 7, 1, d, 1);
        idle(4);
        for (int i = 0; i < 5; i++) begin
            rand_din(d);
            beat(1'(i % 2), 7, 0, d, 1);
        end
        idle(4);
        rd_check("alt_b0", 0, 7);
        rd_check("alt_b1", 1, 7);

        // Toggle the bank while bank-0 beats are still in flight
        for (int i = 0; i < 3; i++) begin
            rand_din(d);
            beat(0, 7, 0, d, 1);
        end
        bank_sel = 1'b1;
        idle(4);
        rd_check("tog_b0", 0, 7);
        rd_check("tog_b1_untouched", 1, 7);
        check_flags("tog");

        // Reset with three overflowing beats in flight; none may land
        d = '{2047, 2047, 2047, 2047};
        beat(1, 2, 0, d, 0);
        beat(1, 2, 0, d, 0);
        beat(1, 2, 0, d, 0);
        check("pre_rst_empty", 64'(empty_s), 64'd0);
        check("pre_rst_flag_sat",  64'(sat_s), 64'hF);
        check("pre_rst_flag_wrap", 64'(sat_w), 64'h0);
        rst = 1'b1;
        #1;
        check("midrst_empty_sat",  64'(empty_s), 64'd1);
        check("midrst_empty_wrap", 64'(empty_w), 64'd1);
        check("midrst_flag_sat",   64'(sat_s),   64'd0);
        check("midrst_rdata",      64'(rdata_s), 64'd0);
        idle(2);
        rst = 1'b0;
        idle(4);
        check("postrst_empty", 64'(empty_s), 64'd1);
        exp_sat_s = '0;
        exp_sat_w = '0;
        check_flags("postrst");
        rd_check("rst_keep", 1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_ch_acc_ram.md
MULTI_CH_ACC_RAM -- requirements
Module: multi_ch_acc_ram

Interface
REQ-001 SHALL have parameter C_MEM_STYLE, default "block": RAM inference style.
REQ-002 SHALL have parameter C_CH, default 4: number of parallel accumulation channels (1..16).
REQ-003 SHALL have parameter C_ISIZE, default 12: signed input width per channel.
REQ-004 SHALL have parameter C_DSIZE, default 24: signed accumulator width per channel (C_DSIZE > C_ISIZE).
REQ-005 SHALL have parameter C_ASIZE, default 10: address width per bank.
REQ-006 SHALL have parameter C_SAT_EN, default 1: 1 = saturate the sum, 0 = wrap the sum.
REQ-007 SHALL have port I_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 SHALL have port I_rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port I_bank_sel, input, 1 bit: write bank for the current beat; reads use ~I_bank_sel.
REQ-010 SHALL have port I_first_flag, input, 1 bit: the beat overwrites the location instead of accumulating.
REQ-011 SHALL have port I_din_valid, input, 1 bit: the beat is valid.
REQ-012 SHALL have port I_waddr, input, C_ASIZE bits: accumulate address.
REQ-013 SHALL have port I_din, input, C_CH*C_ISIZE bits: channel k occupies bits [k*C_ISIZE +: C_ISIZE].
REQ-014 SHALL have port I_rd_en, input, 1 bit: read request.
REQ-015 SHALL have port I_raddr, input, C_ASIZE bits: read address.
REQ-016 SHALL have port I_clr_sat, input, 1 bit: clears O_sat_flag.
REQ-017 SHALL have port O_rdata, output, C_CH*C_DSIZE bits: read data, packed in the same channel order as I_din.
REQ-018 SHALL have port O_rdata_valid, output, 1 bit: O_rdata is valid.
REQ-019 SHALL have port O_sat_flag, output, C_CH bits: sticky per-channel saturation/overflow flag.
REQ-020 SHALL have port O_pipe_empty, output, 1 bit: high when no write is in flight.

Function
REQ-021 SHALL implement an accumulate pipeline with these stages: S0 captures the beat (din, waddr, bank, first); S1 reads the RAM; S2 adds; S3 writes the RAM.
REQ-022 SHALL commit the write 3 cycles after the beat is accepted.
REQ-023 SHALL accept one beat per cycle, with no backpressure.
REQ-024 SHALL compute each channel sum as (first ? 0 : old) + sign_extend(din), in C_DSIZE bits.
REQ-025 SHALL, when C_SAT_EN=1, clamp each channel sum to [-2^(C_DSIZE-1), 2^(C_DSIZE-1)-1] on signed overflow and set the matching O_sat_flag bit.
REQ-026 SHALL, when C_SAT_EN=0, wrap each channel sum and still set the matching O_sat_flag bit on overflow.
REQ-027 SHALL forward the in-flight sum from S2/S3 instead of the stale RAM value whenever a later beat targets the same {bank, waddr}, so that back-to-back and gap-1 same-address beats accumulate correctly.
REQ-028 SHALL latch the bank with each beat at S0, so that toggling I_bank_sel mid-stream never redirects beats already in flight.
REQ-029 SHALL give reads a latency of 2 cycles: O_rdata and O_rdata_valid are registered, and O_rdata_valid is I_rd_en delayed by 2 cycles.
REQ-030 SHALL hold O_rdata when O_rdata_valid is low.
REQ-031 SHALL return the pre-write RAM content when a read and a write hit the same {bank, addr} in the same cycle (read-first).
REQ-032 SHALL drive O_pipe_empty low whenever any of the S0..S3 valids is set.
REQ-033 SHALL give I_clr_sat priority over a simultaneous set of O_sat_flag.
REQ-034 SHALL leave address wrap-around to the caller: addresses are used modulo 2^C_ASIZE, with no range checking.

Reset
REQ-035 SHALL, while I_rst is asserted, clear all pipeline valids, O_rdata_valid and O_sat_flag, and set O_pipe_empty to 1.
REQ-036 SHALL hold O_rdata at 0 after reset until the first read.
REQ-037 SHALL not reset the RAM contents.
REQ-038 SHALL discard in-flight beats when reset asserts mid-stream, with no partial write after reset release.

Structure
REQ-039 SHALL place the saturation bounds, the channel slice width helper, and the pipeline depth constant (3) in the shared cnna package.
REQ-040 SHALL use one sub-module, acc_bank_ram: dual-bank simple dual-port RAM with C_CH*C_DSIZE width and 2^(C_ASIZE+1) depth, a registered read, and a C_MEM_STYLE attribute.

Verification
REQ-041 SHALL cover first-flag accumulation: C_CH=4; beats to addr 5, bank 0, din=3 with first=1, then din=3,3,3 on consecutive cycles; swap bank; read addr 5 -> all channels = 12, O_rdata_valid exactly 2 cycles after I_rd_en.
REQ-042 SHALL cover saturation: C_SAT_EN=1, C_DSIZE=16, C_ISIZE=12; accumulate +2047 twenty times -> 32767 and O_sat_flag set; then pulse I_clr_sat -> flag 0.
REQ-043 SHALL cover wrap mode: C_SAT_EN=0, same stimulus as REQ-042 -> wrapped two's-complement value and O_sat_flag set.
REQ-044 SHALL cover hazard spacing: same address at gaps 0, 1, 2 and 3 cycles -> the sums match a reference model in every case.
REQ-045 SHALL cover a mid-stream bank toggle: beats in flight complete into their latched bank, and the other bank is untouched.
REQ-046 SHALL cover reset mid-stream: assert I_rst with 3 beats in flight -> O_pipe_empty=1, O_sat_flag=0, and the target location holds its pre-beat content.
